// File: rtl/block_sum_accumulator.sv
// rtl/block_sum_accumulator.sv - sums blocks of 2^DIV_LOG2 samples for the rounding divider
module block_sum_accumulator #(
  parameter int DIV_LOG2   = 3,
  parameter int DATA_WIDTH = 32,
  parameter int SUM_WIDTH  = DATA_WIDTH + DIV_LOG2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [SUM_WIDTH-1:0]  sum,
  output logic                  sum_valid,
  input  logic                  sum_ready
);

  localparam logic [DIV_LOG2-1:0] LAST = '1;

  logic [SUM_WIDTH-1:0] acc;
  logic [DIV_LOG2-1:0]  cnt;
  logic [SUM_WIDTH-1:0] din_ext;
  logic                 accept;
  logic                 complete;
  logic                 drain;

  assign din_ext = SUM_WIDTH'(din);

  // Only the block-completing sample waits on the held sum; it may land in the drain cycle.
  assign din_ready = !flush && ((cnt != LAST) || !sum_valid || sum_ready);
  assign accept    = din_valid && din_ready;
  assign complete  = accept && (cnt == LAST);
  assign drain     = sum_valid && sum_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
      cnt <= '0;
    end else if (flush || complete) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc + din_ext;
      cnt <= cnt + DIV_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum       <= '0;
      sum_valid <= 1'b0;
    end else if (complete) begin
      sum       <= acc + din_ext;
      sum_valid <= 1'b1;
    end else if (drain) begin
      sum_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_sum_accumulator.sv
// tb/tb_block_sum_accumulator.sv - directed self-checking bench for block_sum_accumulator
module tb_block_sum_accumulator;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [34:0] sum;
  logic        sum_valid;
  logic        sum_ready;

  int total = 0;
  int bad   = 0;

  block_sum_accumulator dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one sample, wait (bounded) for din_ready, then let it be accepted.
  task automatic send(input logic [31:0] d);
    int w;
    w = 0;
    din       = d;
    din_valid = 1'b1;
    #1;
    while (!din_ready && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) check("send_timeout", 64'd1, 64'd0);
    tick();
    din_valid = 1'b0;
    din       = 'x;
  endtask

  task automatic send_n(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) send(d);
  endtask

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sum_ready = 1'b0;

    // Reset with random input activity
    for (int i = 0; i < 4; i++) begin
      din       = $urandom;
      din_valid = 1'($urandom_range(0, 1));
      tick();
    end
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_sum_valid", 64'(sum_valid), 64'd0);
    din_valid = 1'b0;
    resetn    = 1'b1;
    #1;
    check("rst_din_ready", 64'(din_ready), 64'd1);

    // Basic back-to-back blocks
    sum_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(32'(i));
    check("basic_sum1", 64'(sum), 64'd36);
    check("basic_valid1", 64'(sum_valid), 64'd1);
    send(32'd9);
    check("basic_one_cycle", 64'(sum_valid), 64'd0);
    for (int i = 10; i <= 16; i++) send(32'(i));
    check("basic_sum2", 64'(sum), 64'd100);
    check("basic_valid2", 64'(sum_valid), 64'd1);
    tick();
    check("basic_drained", 64'(sum_valid), 64'd0);

    // Max value, then the same with gaps and X on idle din
    send_n(32'hFFFF_FFFF, 8);
    check("max_sum", 64'(sum), 64'h7_FFFF_FFF8);
    tick();
    for (int i = 0; i < 8; i++) begin
      send(32'hFFFF_FFFF);
      repeat ($urandom_range(0, 3)) tick();
    end
    check("max_gap_sum", 64'(sum), 64'h7_FFFF_FFF8);
    tick();
    check("max_gap_drained", 64'(sum_valid), 64'd0);

    // Backpressure: second block's last sample stalls until drain
    sum_ready = 1'b0;
    send_n(32'd2, 8);
    check("bp_sum_held", 64'(sum), 64'd16);
    check("bp_valid_held", 64'(sum_valid), 64'd1);
    send_n(32'd2, 7);
    din       = 32'd2;
    din_valid = 1'b1;
    #1;
    check("bp_stall", 64'(din_ready), 64'd0);
    tick();
    check("bp_stable_sum", 64'(sum), 64'd16);
    check("bp_stable_valid", 64'(sum_valid), 64'd1);
    sum_ready = 1'b1;
    #1;
    check("bp_ready_on_drain", 64'(din_ready), 64'd1);
    tick();
    sum_ready = 1'b0;
    din_valid = 1'b0;
    check("bp_sum_again", 64'(sum), 64'd16);
    check("bp_valid_again", 64'(sum_valid), 64'd1);
    sum_ready = 1'b1;
    tick();
    check("bp_drained", 64'(sum_valid), 64'd0);

    // Flush discards partial block
    send_n(32'd5, 3);
    flush     = 1'b1;
    din       = 32'd99;
    din_valid = 1'b1;
    #1;
    check("flush_no_ready", 64'(din_ready), 64'd0);
    tick();
    flush     = 1'b0;
    din_valid = 1'b0;
    send_n(32'd1, 8);
    check("flush_sum", 64'(sum), 64'd8);
    tick();

    // Flush with a pending sum: it drains intact
    sum_ready = 1'b0;
    send_n(32'd4, 8);
    send_n(32'd2, 5);
    flush     = 1'b1;
    sum_ready = 1'b1;
    #1;
    check("flush_pending_sum", 64'(sum), 64'd32);
    check("flush_pending_valid", 64'(sum_valid), 64'd1);
    tick();
    flush = 1'b0;
    check("flush_pending_drained", 64'(sum_valid), 64'd0);
    send_n(32'd1, 8);
    check("flush_after_sum", 64'(sum), 64'd8);
    tick();

    // Async reset mid-cycle with a sum pending and a partial block
    sum_ready = 1'b0;
    send_n(32'd3, 8);
    send_n(32'd5, 5);
    #2;
    resetn = 1'b0;
    #1;
    check("areset_sum", 64'(sum), 64'd0);
    check("areset_valid", 64'(sum_valid), 64'd0);
    tick();
    resetn = 1'b1;
    send_n(32'd3, 8);
    check("areset_after_sum", 64'(sum), 64'd24);
    check("areset_after_valid", 64'(sum_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
